// File: rtl/nasti_ddrx_pkg.sv
// rtl/nasti_ddrx_pkg.sv - shared types, address-map defaults and map function for the DDRx command scheduler
package nasti_ddrx_pkg;

   typedef enum logic [1:0] {
      CMD_ACT = 2'd0,
      CMD_RD  = 2'd1,
      CMD_WR  = 2'd2,
      CMD_PRE = 2'd3
   } cmd_type_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2
   } sched_state_e;

   // Default geometry: 64-bit beats, 1K columns, 8 banks, 64K rows
   localparam int DEF_OFFSET_BITS = 3;
   localparam int DEF_COL_WIDTH   = 10;
   localparam int DEF_BANK_WIDTH  = 3;
   localparam int DEF_ROW_WIDTH   = 16;
   localparam int DEF_COL_LSB     = DEF_OFFSET_BITS;
   localparam int DEF_BANK_LSB    = DEF_COL_LSB + DEF_COL_WIDTH;
   localparam int DEF_ROW_LSB     = DEF_BANK_LSB + DEF_BANK_WIDTH;

   // Fields are returned at a fixed generous width; callers keep the low bits they need
   typedef struct packed {
      logic [31:0] bank;
      logic [31:0] row;
      logic [31:0] col;
   } addr_fields_t;

   function automatic logic [63:0] field_mask(input int width);
      return (64'd1 << width) - 64'd1;
   endfunction

   // Address map, LSB up: byte offset, column, bank, row; anything above the row is dropped
   function automatic addr_fields_t map_addr(input logic [63:0] addr,
                                             input int offset_bits,
                                             input int col_width,
                                             input int bank_width,
                                             input int row_width);
      addr_fields_t f;
      logic [63:0]  a;
      a      = addr >> offset_bits;
      f.col  = 32'(a & field_mask(col_width));
      a      = a >> col_width;
      f.bank = 32'(a & field_mask(bank_width));
      a      = a >> bank_width;
      f.row  = 32'(a & field_mask(row_width));
      return f;
   endfunction

endpackage

// File: rtl/nasti_ddrx_bank_table.sv
// rtl/nasti_ddrx_bank_table.sv - per-bank open flag and open-row store
module nasti_ddrx_bank_table
   import nasti_ddrx_pkg::*;
#(
   parameter int BANK_WIDTH = DEF_BANK_WIDTH,
   parameter int ROW_WIDTH  = DEF_ROW_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  upd_en,
   input  logic [BANK_WIDTH-1:0] upd_bank,
   input  logic                  upd_open,
   input  logic [ROW_WIDTH-1:0]  upd_row,
   input  logic [BANK_WIDTH-1:0] lookup_bank,
   output logic                  lookup_open,
   output logic [ROW_WIDTH-1:0]  lookup_row
);

   localparam int NUM_BANKS = 1 << BANK_WIDTH;

   logic [NUM_BANKS-1:0] open_q;
   logic [ROW_WIDTH-1:0] row_q [NUM_BANKS];

   // Open/close a bank on accepted ACT/PRE; rows are only rewritten on open
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         open_q <= '0;
         for (int i = 0; i < NUM_BANKS; i++) begin
            row_q[i] <= '0;
         end
      end else if (upd_en) begin
         open_q[upd_bank] <= upd_open;
         if (upd_open) begin
            row_q[upd_bank] <= upd_row;
         end
      end
   end

   assign lookup_open = open_q[lookup_bank];
   assign lookup_row  = row_q[lookup_bank];

endmodule

// File: rtl/nasti_ddrx_cmd_sched.sv
// rtl/nasti_ddrx_cmd_sched.sv - AR/AW arbitration and ACT/RD/WR/PRE command generation with tRP/tRCD
module nasti_ddrx_cmd_sched
   import nasti_ddrx_pkg::*;
#(
   parameter int C_NASTI_ID_WIDTH   = 9,
   parameter int C_NASTI_ADDR_WIDTH = 32,
   parameter int C_NASTI_DATA_WIDTH = 64,
   parameter int C_COL_WIDTH        = 10,
   parameter int C_BANK_WIDTH       = 3,
   parameter int C_ROW_WIDTH        = 16,
   parameter int C_TRP              = 4,
   parameter int C_TRCD             = 4,
   parameter int C_ARB_MODE         = 1,
   parameter int C_STARVE_LIMIT     = 4
) (
   input  logic                          core_clk,
   input  logic                          core_arst,
   input  logic [C_NASTI_ADDR_WIDTH-1:0] ar_addr,
   input  logic [7:0]                    ar_len,
   input  logic [C_NASTI_ID_WIDTH-1:0]   ar_id,
   input  logic                          ar_empty,
   output logic                          ar_inc,
   input  logic [C_NASTI_ADDR_WIDTH-1:0] aw_addr,
   input  logic [7:0]                    aw_len,
   input  logic [C_NASTI_ID_WIDTH-1:0]   aw_id,
   input  logic                          aw_empty,
   output logic                          aw_inc,
   output logic                          cmd_valid,
   input  logic                          cmd_ready,
   output logic [1:0]                    cmd_type,
   output logic [C_BANK_WIDTH-1:0]       cmd_bank,
   output logic [C_ROW_WIDTH-1:0]        cmd_row,
   output logic [C_COL_WIDTH-1:0]        cmd_col,
   output logic [C_NASTI_ID_WIDTH-1:0]   cmd_id,
   output logic                          cmd_last
);

   localparam int         OFF_BITS   = $clog2(C_NASTI_DATA_WIDTH / 8);
   localparam logic [7:0] TRP_WAIT   = 8'(C_TRP - 1);
   localparam logic [7:0] TRCD_WAIT  = 8'(C_TRCD - 1);
   localparam logic [7:0] STARVE_MAX = 8'(C_STARVE_LIMIT);

   sched_state_e state, state_next;

   logic [C_NASTI_ADDR_WIDTH-1:0] cur_addr;
   logic [7:0]                    cur_len;
   logic [C_NASTI_ID_WIDTH-1:0]   cur_id;
   logic                          cur_write;
   logic [7:0]                    beat_cnt;
   logic [7:0]                    wait_cnt;
   logic [7:0]                    starve_cnt;
   logic                          last_write;

   logic [C_NASTI_ADDR_WIDTH-1:0] beat_addr;
   addr_fields_t                  beat_fields;
   logic                          unused_fields;
   logic [C_BANK_WIDTH-1:0]       beat_bank;
   logic [C_ROW_WIDTH-1:0]        beat_row;
   logic [C_COL_WIDTH-1:0]        beat_col;
   logic                          bank_open;
   logic [C_ROW_WIDTH-1:0]        bank_row;

   cmd_type_e  sel_type;
   logic       is_cas;
   logic       last_beat;
   logic       hs;
   logic       pop;
   logic       pick_write;
   logic [7:0] wait_load;

   // Every beat is remapped, so bank/row crossings inside a burst become ordinary misses
   assign beat_addr     = cur_addr + (C_NASTI_ADDR_WIDTH'(beat_cnt) << OFF_BITS);
   assign beat_fields   = map_addr(64'(beat_addr), OFF_BITS, C_COL_WIDTH, C_BANK_WIDTH, C_ROW_WIDTH);
   assign unused_fields = ^beat_fields;
   assign beat_bank     = beat_fields.bank[C_BANK_WIDTH-1:0];
   assign beat_row      = beat_fields.row[C_ROW_WIDTH-1:0];
   assign beat_col      = beat_fields.col[C_COL_WIDTH-1:0];

   nasti_ddrx_bank_table #(
      .BANK_WIDTH (C_BANK_WIDTH),
      .ROW_WIDTH  (C_ROW_WIDTH)
   ) u_bank_table (
      .clk         (core_clk),
      .rst         (core_arst),
      .upd_en      (hs && !is_cas),
      .upd_bank    (beat_bank),
      .upd_open    (sel_type == CMD_ACT),
      .upd_row     (beat_row),
      .lookup_bank (beat_bank),
      .lookup_open (bank_open),
      .lookup_row  (bank_row)
   );

   // Command for the current beat follows directly from the bank's open state
   always_comb begin
      sel_type = CMD_ACT;
      if (!bank_open) begin
         sel_type = CMD_ACT;
      end else if (bank_row != beat_row) begin
         sel_type = CMD_PRE;
      end else begin
         sel_type = cur_write ? CMD_WR : CMD_RD;
      end
   end

   assign is_cas    = (sel_type == CMD_RD) || (sel_type == CMD_WR);
   assign last_beat = (beat_cnt == cur_len);
   assign hs        = (state == ST_ISSUE) && cmd_ready;
   assign wait_load = (sel_type == CMD_PRE) ? TRP_WAIT : TRCD_WAIT;

   // Queue choice: alternate in mode 0, read-first with a write-starvation cap in mode 1
   always_comb begin
      pick_write = 1'b0;
      if (C_ARB_MODE == 0) begin
         pick_write = !aw_empty && (ar_empty || !last_write);
      end else begin
         pick_write = !aw_empty && (ar_empty || (starve_cnt == STARVE_MAX));
      end
   end

   // State register
   always_ff @(posedge core_clk or posedge core_arst) begin
      if (core_arst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next state and pop decision
   always_comb begin
      state_next = state;
      pop        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!ar_empty || !aw_empty) begin
               pop        = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (cmd_ready) begin
               if (is_cas) begin
                  if (last_beat) begin
                     state_next = ST_IDLE;
                  end
               end else if (wait_load != 8'd0) begin
                  state_next = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (wait_cnt == 8'd1) begin
               state_next = ST_ISSUE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Transaction latch, beat counter, timing counter and arbitration history
   always_ff @(posedge core_clk or posedge core_arst) begin
      if (core_arst) begin
         cur_addr   <= '0;
         cur_len    <= '0;
         cur_id     <= '0;
         cur_write  <= 1'b0;
         beat_cnt   <= '0;
         wait_cnt   <= '0;
         starve_cnt <= '0;
         last_write <= 1'b1;
      end else begin
         if (pop) begin
            cur_addr   <= pick_write ? aw_addr : ar_addr;
            cur_len    <= pick_write ? aw_len : ar_len;
            cur_id     <= pick_write ? aw_id : ar_id;
            cur_write  <= pick_write;
            beat_cnt   <= '0;
            last_write <= pick_write;
            if (pick_write) begin
               starve_cnt <= '0;
            end else if (!aw_empty && (starve_cnt != STARVE_MAX)) begin
               starve_cnt <= starve_cnt + 8'd1;
            end
         end
         if (hs && is_cas && !last_beat) begin
            beat_cnt <= beat_cnt + 8'd1;
         end
         if (hs && !is_cas) begin
            wait_cnt <= wait_load;
         end else if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt - 8'd1;
         end
      end
   end

   // Pops are masked during reset so a waiting queue is never consumed while the block is held
   assign ar_inc    = pop && !pick_write && !core_arst;
   assign aw_inc    = pop && pick_write && !core_arst;
   assign cmd_valid = (state == ST_ISSUE);
   assign cmd_type  = cmd_valid ? sel_type : 2'd0;
   assign cmd_bank  = cmd_valid ? beat_bank : '0;
   assign cmd_row   = cmd_valid ? beat_row : '0;
   assign cmd_col   = cmd_valid ? beat_col : '0;
   assign cmd_id    = cmd_valid ? cur_id : '0;
   assign cmd_last  = cmd_valid && is_cas && last_beat;

endmodule

// File: tb/tb_nasti_ddrx_cmd_sched.sv
// tb/tb_nasti_ddrx_cmd_sched.sv - scoreboard bench for the DDRx command scheduler
module tb_nasti_ddrx_cmd_sched;

   localparam logic [1:0] T_ACT = 2'd0;
   localparam logic [1:0] T_RD  = 2'd1;
   localparam logic [1:0] T_WR  = 2'd2;
   localparam logic [1:0] T_PRE = 2'd3;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] ar_addr, aw_addr;
   logic [7:0]  ar_len, aw_len;
   logic [8:0]  ar_id, aw_id;
   logic        ar_empty, aw_empty, ar_inc, aw_inc;
   logic        cmd_valid, cmd_ready, cmd_last;
   logic [1:0]  cmd_type;
   logic [2:0]  cmd_bank;
   logic [15:0] cmd_row;
   logic [9:0]  cmd_col;
   logic [8:0]  cmd_id;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int last_hs = 0;
   int hs_cnt  = 0;

   always #5 clk = ~clk;

   nasti_ddrx_cmd_sched dut (
      .core_clk  (clk),
      .core_arst (rst),
      .ar_addr   (ar_addr),
      .ar_len    (ar_len),
      .ar_id     (ar_id),
      .ar_empty  (ar_empty),
      .ar_inc    (ar_inc),
      .aw_addr   (aw_addr),
      .aw_len    (aw_len),
      .aw_id     (aw_id),
      .aw_empty  (aw_empty),
      .aw_inc    (aw_inc),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_type  (cmd_type),
      .cmd_bank  (cmd_bank),
      .cmd_row   (cmd_row),
      .cmd_col   (cmd_col),
      .cmd_id    (cmd_id),
      .cmd_last  (cmd_last)
   );

   // Frontend FWFT queue models
   logic [31:0] ar_mem_addr [64];
   logic [7:0]  ar_mem_len  [64];
   logic [8:0]  ar_mem_id   [64];
   logic [31:0] aw_mem_addr [64];
   logic [7:0]  aw_mem_len  [64];
   logic [8:0]  aw_mem_id   [64];
   int ar_wr = 0, ar_rd = 0, aw_wr = 0, aw_rd = 0;

   assign ar_empty = (ar_rd == ar_wr);
   assign aw_empty = (aw_rd == aw_wr);
   assign ar_addr  = ar_mem_addr[ar_rd % 64];
   assign ar_len   = ar_mem_len[ar_rd % 64];
   assign ar_id    = ar_mem_id[ar_rd % 64];
   assign aw_addr  = aw_mem_addr[aw_rd % 64];
   assign aw_len   = aw_mem_len[aw_rd % 64];
   assign aw_id    = aw_mem_id[aw_rd % 64];

   // Queue pop on inc
   always @(posedge clk) begin
      if (ar_inc && !ar_empty) ar_rd <= ar_rd + 1;
      if (aw_inc && !aw_empty) aw_rd <= aw_rd + 1;
   end

   typedef struct {
      logic [1:0] typ;
      int         bank;
      int         row;
      int         col;
      int         id;
      bit         last;
      int         gap;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;

   task automatic push_ar(input logic [31:0] addr, input logic [7:0] len, input logic [8:0] id);
      ar_mem_addr[ar_wr % 64] = addr;
      ar_mem_len[ar_wr % 64]  = len;
      ar_mem_id[ar_wr % 64]   = id;
      ar_wr = ar_wr + 1;
   endtask

   task automatic push_aw(input logic [31:0] addr, input logic [7:0] len, input logic [8:0] id);
      aw_mem_addr[aw_wr % 64] = addr;
      aw_mem_len[aw_wr % 64]  = len;
      aw_mem_id[aw_wr % 64]   = id;
      aw_wr = aw_wr + 1;
   endtask

   // gap = cycles since the previous accepted command, 0 = not checked
   task automatic expect_cmd(input logic [1:0] typ, input int bank, input int row, input int col,
                             input int id, input bit last, input int gap);
      exp_t x;
      x.typ = typ; x.bank = bank; x.row = row; x.col = col;
      x.id = id; x.last = last; x.gap = gap;
      exp_q.push_back(x);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(posedge clk);
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain_%s actual_pending=%0d required=0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   // Monitor: compares every accepted command against the scoreboard head
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (ar_inc || aw_inc) begin
            total++;
            if ((ar_inc && ar_empty) || (aw_inc && aw_empty) || (ar_inc && aw_inc)) begin
               bad++;
               $display("FAIL inc_legal actual ar_inc=%0b ar_empty=%0b aw_inc=%0b aw_empty=%0b required=single_pop_of_nonempty",
                        ar_inc, ar_empty, aw_inc, aw_empty);
            end
         end
         if (cmd_valid && cmd_ready) begin
            hs_cnt++;
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_cmd actual type=%0d bank=%0d col=%0h id=%0d required=none",
                        cmd_type, cmd_bank, cmd_col, cmd_id);
            end else begin
               e = exp_q.pop_front();
               if (cmd_type != e.typ || int'(cmd_bank) != e.bank || int'(cmd_id) != e.id ||
                   cmd_last != e.last ||
                   (e.typ == T_ACT && int'(cmd_row) != e.row) ||
                   ((e.typ == T_RD || e.typ == T_WR) && int'(cmd_col) != e.col) ||
                   (e.gap != 0 && (cyc - last_hs) != e.gap)) begin
                  bad++;
                  $display("FAIL cmd actual type=%0d bank=%0d row=%0h col=%0h id=%0d last=%0b gap=%0d required type=%0d bank=%0d row=%0h col=%0h id=%0d last=%0b gap=%0d",
                           cmd_type, cmd_bank, cmd_row, cmd_col, cmd_id, cmd_last, cyc - last_hs,
                           e.typ, e.bank, e.row, e.col, e.id, e.last, e.gap);
               end
            end
            last_hs = cyc;
         end
      end
   end

   initial begin
      int n;
      int target;
      rst       = 1'b1;
      cmd_ready = 1'b1;

      // Burst hit from reset, then a row miss on the same bank
      push_ar(32'h0000_2000, 8'd3, 9'd5);
      push_ar(32'h0001_2000, 8'd0, 9'd6);
      expect_cmd(T_ACT, 1, 0, 0, 5, 1'b0, 0);
      expect_cmd(T_RD,  1, 0, 0, 5, 1'b0, 4);
      expect_cmd(T_RD,  1, 0, 1, 5, 1'b0, 1);
      expect_cmd(T_RD,  1, 0, 2, 5, 1'b0, 1);
      expect_cmd(T_RD,  1, 0, 3, 5, 1'b1, 1);
      expect_cmd(T_PRE, 1, 0, 0, 6, 1'b0, 2);
      expect_cmd(T_ACT, 1, 1, 0, 6, 1'b0, 4);
      expect_cmd(T_RD,  1, 1, 0, 6, 1'b1, 4);
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs",
            64'({cmd_valid, ar_inc, aw_inc, cmd_type, cmd_bank, cmd_row, cmd_col, cmd_id, cmd_last}),
            64'd0);
      rst = 1'b0;
      #3;
      check("pop_cycle", 64'({ar_inc, aw_inc, cmd_valid}), 64'b100);
      @(posedge clk); #1;
      check("valid_next_cycle", 64'({ar_inc, cmd_valid}), 64'b01);
      drain("hit_miss");

      // Burst crossing a bank boundary from closed banks
      do_reset();
      push_ar(32'h0000_1FF8, 8'd1, 9'd3);
      expect_cmd(T_ACT, 0, 0, 0,     3, 1'b0, 0);
      expect_cmd(T_RD,  0, 0, 10'h3FF, 3, 1'b0, 4);
      expect_cmd(T_ACT, 1, 0, 0,     3, 1'b0, 1);
      expect_cmd(T_RD,  1, 0, 0,     3, 1'b1, 4);
      drain("bank_cross");

      // Read priority with starvation limit: open rows first, then the mixed batch
      do_reset();
      push_ar(32'h0000_4000, 8'd0, 9'd1);
      push_aw(32'h0000_6000, 8'd0, 9'd2);
      expect_cmd(T_ACT, 2, 0, 0, 1, 1'b0, 0);
      expect_cmd(T_RD,  2, 0, 0, 1, 1'b1, 4);
      expect_cmd(T_ACT, 3, 0, 0, 2, 1'b0, 2);
      expect_cmd(T_WR,  3, 0, 0, 2, 1'b1, 4);
      drain("preopen");
      for (int k = 0; k < 6; k++) begin
         push_ar(32'h0000_4000 + 32'(k * 8), 8'd0, 9'(10 + k));
      end
      push_aw(32'h0000_6008, 8'd0, 9'd20);
      push_aw(32'h0000_6010, 8'd0, 9'd21);
      expect_cmd(T_RD, 2, 0, 0, 10, 1'b1, 0);
      expect_cmd(T_RD, 2, 0, 1, 11, 1'b1, 2);
      expect_cmd(T_RD, 2, 0, 2, 12, 1'b1, 2);
      expect_cmd(T_RD, 2, 0, 3, 13, 1'b1, 2);
      expect_cmd(T_WR, 3, 0, 1, 20, 1'b1, 2);
      expect_cmd(T_RD, 2, 0, 4, 14, 1'b1, 2);
      expect_cmd(T_RD, 2, 0, 5, 15, 1'b1, 2);
      expect_cmd(T_WR, 3, 0, 2, 21, 1'b1, 2);
      drain("starve");

      // Backpressure on an ACT: fields hold, tRCD counts from acceptance
      do_reset();
      cmd_ready = 1'b0;
      push_ar(32'h0000_8000, 8'd0, 9'd7);
      expect_cmd(T_ACT, 4, 0, 0, 7, 1'b0, 0);
      expect_cmd(T_RD,  4, 0, 0, 7, 1'b1, 4);
      n = 0;
      while (!cmd_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("act_presented", 64'(cmd_valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         check("act_stable", 64'({cmd_valid, cmd_type, cmd_bank, cmd_row, cmd_id, cmd_last}),
               64'({1'b1, T_ACT, 3'd4, 16'd0, 9'd7, 1'b0}));
         @(posedge clk); #1;
      end
      cmd_ready = 1'b1;
      drain("backpressure");

      // Reset during beat 2 of a long burst; the next transaction must re-open the row
      do_reset();
      push_ar(32'h0000_A000, 8'd7, 9'd9);
      push_ar(32'h0000_A000, 8'd0, 9'd11);
      expect_cmd(T_ACT, 5, 0, 0, 9, 1'b0, 0);
      expect_cmd(T_RD,  5, 0, 0, 9, 1'b0, 4);
      expect_cmd(T_RD,  5, 0, 1, 9, 1'b0, 1);
      target = hs_cnt + 3;
      n = 0;
      while (hs_cnt < target && n < 100) begin
         @(posedge clk);
         n++;
      end
      check("reach_beat1", 64'(hs_cnt >= target), 64'd1);
      #2;
      check("beat2_presented", 64'({cmd_valid, cmd_col}), 64'({1'b1, 10'd2}));
      rst = 1'b1;
      #1;
      check("async_reset_outputs", 64'({cmd_valid, ar_inc, aw_inc, ar_empty}), 64'b0000);
      #1 rst = 1'b0;
      expect_cmd(T_ACT, 5, 0, 0, 11, 1'b0, 0);
      expect_cmd(T_RD,  5, 0, 0, 11, 1'b1, 4);
      drain("mid_reset");

      check("queues_consumed", 64'({ar_rd == ar_wr, aw_rd == aw_wr}), 64'b11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
